// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM states, watchdog sizing and header byte layout for uart_tx_arbiter
package uart_arb_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, WAIT_LO, WAIT_HI} state_t;
  localparam int HDR_ID_LSB = 0;
  function automatic int wd_w(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: channel streams, serializer handshake and status; slave = arbiter side, master = environment side
interface uart_tx_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int IW = $clog2(NUM_CH);
  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tlast;
  logic [NUM_CH-1:0]        s_tready;
  logic [DATA_W-1:0]        m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic [IW-1:0]            grant_id;
  logic                     busy;
  logic                     timeout_err;
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, grant_id, busy, timeout_err
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; i_req requests, i_ptr last winner, o_idx next winner, o_any any request
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IW-1:0]     i_ptr,
  output logic [IW-1:0]     o_idx,
  output logic              o_any
);
  logic [IW-1:0] w_c;
  // scan from farthest to nearest so the channel closest after i_ptr is the last one written
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_c = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_c = IW'((int'(i_ptr) + k) % NUM_CH);
      if (i_req[w_c]) begin
        o_idx = w_c;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART TX among NUM_CH byte streams
// Ports: clk, rst (async, active-high), bus (uart_tx_arbiter_if.slave: s_t* channel streams,
// m_t* serializer handshake, grant_id, busy, timeout_err). Macro UART_ARB_HDR_EN adds a grant_id header byte per packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CH);
  localparam int WW = wd_w(TIMEOUT);
  localparam state_t ST_FIRST =
`ifdef UART_ARB_HDR_EN
    HDR;
`else
    FETCH;
`endif
  state_t r_state, w_next;
  logic [IW-1:0] r_gnt, r_ptr, w_pick;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_bytes [NUM_CH];
  logic [NUM_CH-1:0] w_rdy;
  logic [WW-1:0] r_wd;
  logic r_last, r_to, w_any, w_v, w_exp, w_offer;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_byte
    assign w_bytes[i] = bus.s_tdata[i*DATA_W +: DATA_W];
  end
  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .i_req(bus.s_tvalid),
    .i_ptr(r_ptr),
    .o_idx(w_pick),
    .o_any(w_any)
  );
  assign w_v = bus.s_tvalid[r_gnt];
  assign w_exp = (TIMEOUT != 0) && r_state == FETCH && !w_v && r_wd == WW'(TIMEOUT - 1);
`ifdef UART_ARB_HDR_EN
  assign w_offer = r_state == SEND || r_state == HDR;
`else
  assign w_offer = r_state == SEND;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_rdy = '0;
    case (r_state)
      IDLE: w_next = w_any ? ST_FIRST : IDLE;
`ifdef UART_ARB_HDR_EN
      HDR, SEND: w_next = bus.m_tready ? WAIT_LO : r_state;
`else
      SEND: w_next = bus.m_tready ? WAIT_LO : SEND;
`endif
      FETCH: begin
        w_rdy[r_gnt] = w_v;
        w_next = w_v ? SEND : w_exp ? IDLE : FETCH;
      end
      WAIT_LO: w_next = bus.m_tready ? WAIT_LO : WAIT_HI;
      WAIT_HI: w_next = !bus.m_tready ? WAIT_HI : r_last ? IDLE : FETCH;
      default: w_next = IDLE;
    endcase
  end
  // rr_ptr tracks the last grant, so a watchdog release already advances the search past the stalled channel
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_gnt <= '0;
      r_ptr <= IW'(NUM_CH - 1);
      r_data <= '0;
      r_last <= 1'b0;
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      r_to <= w_exp;
      r_wd <= (r_state == FETCH && !w_v && !w_exp) ? r_wd + 1'b1 : '0;
      if (r_state == IDLE && w_any) begin
        r_gnt <= w_pick;
        r_ptr <= w_pick;
        r_last <= 1'b0;
`ifdef UART_ARB_HDR_EN
        r_data <= DATA_W'(w_pick) << HDR_ID_LSB;
`endif
      end
      if (r_state == FETCH && w_v) begin
        r_data <= w_bytes[r_gnt];
        r_last <= bus.s_tlast[r_gnt];
      end
    end
  assign bus.s_tready = w_rdy;
  assign bus.m_tvalid = w_offer;
  assign bus.m_tdata = r_data;
  assign bus.grant_id = r_gnt;
  assign bus.busy = r_state != IDLE;
  assign bus.timeout_err = r_to;
endmodule
